seg7_scan_driver: RTL and testbench

- Consumer side of the ScoreCounter-style 28-bit display word: four 7-segment patterns, active-low segments; digit 3 = [27:21] (leftmost), digit 0 = [6:0] (rightmost).
- Time-multiplexes the word onto the board's common-anode 4-digit display.
- Latches the word once per frame, so a score update never tears mid-scan.
- Inserts an all-anodes-off guard interval before each digit to suppress ghosting.

---
 rtl/seg7_scan_driver_if.sv | 20 ++
 rtl/seg7_scan_driver.sv | 94 +++++++++
 tb/tb_seg7_scan_driver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: the packed display word and blank
// request going in, and the registered anode, segment and scan-status signals coming out.
interface seg7_scan_driver_if;
    logic [27:0] display_all;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_done;

    modport master (
        output display_all, blank,
        input  an, seg, digit_idx, frame_done
    );

    modport slave (
        input  display_all, blank,
        output an, seg, digit_idx, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Scans a 4-digit common-anode 7-segment display. The word is latched once per frame, and each digit slot starts with an all-off guard.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN keeps leading ZERO digits dark. Digit 0 is always shown.
module seg7_scan_driver #(
    parameter int unsigned DIV_CYCLES   = 100000,
    parameter int unsigned GUARD_CYCLES = 1000
) (
    input logic               game_clk,
    input logic               rst,
    seg7_scan_driver_if.slave disp
);
    localparam int unsigned   CW        = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);
    localparam logic [6:0]    SEG_OFF   = '1;
    localparam logic [6:0]    SEG_ZERO  = 7'b1000000;

    typedef enum logic {PH_GUARD, PH_ON} phase_t;

    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    idx, idx_next;
    logic [27:0]   frame_buf, buf_next;
    logic          frame_wrap;
    logic          suppress;
    logic [6:0]    seg_next;
    phase_t        phase_next;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          frame_done_r;

    always_comb begin
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        frame_wrap = 1'b0;
        if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            idx_next   = idx + 2'd1;
            frame_wrap = (idx == 2'd3);
        end
        buf_next = frame_wrap ? disp.display_all : frame_buf;
        // Outputs are registered, so the phase is judged on the upcoming count.
        phase_next = (cnt_next < CNT_GUARD) ? PH_GUARD : PH_ON;
        case (idx_next)
            2'd0:    seg_next = buf_next[6:0];
            2'd1:    seg_next = buf_next[13:7];
            2'd2:    seg_next = buf_next[20:14];
            default: seg_next = buf_next[27:21];
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lz3, lz2, lz1;
    always_comb begin
        lz3 = (buf_next[27:21] == SEG_ZERO);
        lz2 = lz3 && (buf_next[20:14] == SEG_ZERO);
        lz1 = lz2 && (buf_next[13:7] == SEG_ZERO);
        case (idx_next)
            2'd3:    suppress = lz3;
            2'd2:    suppress = lz2;
            2'd1:    suppress = lz1;
            default: suppress = 1'b0;
        endcase
    end
`else
    always_comb suppress = 1'b0;
`endif

    always_ff @(posedge game_clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            frame_buf    <= disp.display_all;
            an_r         <= '1;
            seg_r        <= SEG_OFF;
            frame_done_r <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            idx          <= idx_next;
            frame_buf    <= buf_next;
            frame_done_r <= frame_wrap;
            if (disp.blank || phase_next == PH_GUARD || suppress) begin
                an_r  <= '1;
                seg_r <= SEG_OFF;
            end else begin
                an_r  <= ~(4'b0001 << idx_next);
                seg_r <= seg_next;
            end
        end
    end

    assign disp.an         = an_r;
    assign disp.seg        = seg_r;
    assign disp.digit_idx  = idx;
    assign disp.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver. The expected outputs are derived arithmetically from the number of edges since reset release.
module tb_seg7_scan_driver;
    localparam int unsigned DIV   = 16;
    localparam int unsigned GUARD = 4;
    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam logic [6:0] ONE   = 7'b1111001;
    localparam logic [6:0] TWO   = 7'b0100100;
    localparam logic [6:0] THREE = 7'b0110000;
    localparam logic [6:0] FOUR  = 7'b0011001;
    localparam logic [6:0] FIVE  = 7'b0010010;
    localparam logic [6:0] SIX   = 7'b0000010;
    localparam logic [6:0] SEVEN = 7'b1111000;
    localparam logic [6:0] EIGHT = 7'b0000000;

    logic game_clk = 1'b0;
    logic rst = 1'b1;
    seg7_scan_driver_if disp();

    seg7_scan_driver #(.DIV_CYCLES(DIV), .GUARD_CYCLES(GUARD)) dut (
        .game_clk(game_clk),
        .rst     (rst),
        .disp    (disp)
    );

    always #5 game_clk = ~game_clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned t        = 0;
    logic [27:0] mbuf     = '0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, want, t, $time);
        end
    endtask

    function automatic logic [6:0] slice(input logic [27:0] w, input int unsigned i);
        return w[7*i +: 7];
    endfunction

    function automatic bit lead_dark(input logic [27:0] w, input int unsigned i);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (i == 0) return 1'b0;
        for (int unsigned j = i; j < 4; j++)
            if (slice(w, j) != ZERO) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // One clock edge: advance the reference model, then compare just after the edge.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic [1:0] e_idx;
        logic       e_fd;
        int unsigned slot, pos;
        @(posedge game_clk);
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_idx = 2'd0;
        e_fd  = 1'b0;
        if (rst) begin
            t    = 0;
            mbuf = disp.display_all;
        end else begin
            t++;
            e_fd = ((t % (4*DIV)) == 0);
            if (e_fd) mbuf = disp.display_all;
            slot  = (t / DIV) % 4;
            pos   = t % DIV;
            e_idx = 2'(slot);
            if (pos >= GUARD && !disp.blank && !lead_dark(mbuf, slot)) begin
                e_an[slot] = 1'b0;
                e_seg      = slice(mbuf, slot);
            end
        end
        #1;
        expect_eq("an", 32'(disp.an), 32'(e_an));
        expect_eq("seg", 32'(disp.seg), 32'(e_seg));
        expect_eq("digit_idx", 32'(disp.digit_idx), 32'(e_idx));
        expect_eq("frame_done", 32'(disp.frame_done), 32'(e_fd));
    endtask

    task automatic run(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic do_reset(input logic [27:0] w);
        rst = 1'b1;
        disp.display_all = w;
        disp.blank = 1'b0;
        run(2);
        expect_eq("reset_an", 32'(disp.an), 32'hF);
        expect_eq("reset_seg", 32'(disp.seg), 32'h7F);
        rst = 1'b0;
    endtask

    function automatic logic [27:0] rand_word();
        logic [27:0] w;
        logic [31:0] r;
        for (int unsigned i = 0; i < 4; i++) begin
            r = $urandom;
            w[7*i +: 7] = (r[0] || r[1]) ? ZERO : r[8:2];
        end
        return w;
    endfunction

    initial begin
        disp.display_all = '0;
        disp.blank = 1'b0;

        // Basic scan timing and frame latching.
        do_reset({ONE, TWO, THREE, FOUR});
        run(3);
        expect_eq("guard_e3_an", 32'(disp.an), 32'hF);
        step();
        expect_eq("on_e4_an", 32'(disp.an), 32'b1110);
        expect_eq("on_e4_seg", 32'(disp.seg), 32'(FOUR));
        run(11);
        expect_eq("on_e15_an", 32'(disp.an), 32'b1110);
        step();
        expect_eq("guard_e16_an", 32'(disp.an), 32'hF);
        run(4);
        expect_eq("d1_e20_an", 32'(disp.an), 32'b1101);
        expect_eq("d1_e20_seg", 32'(disp.seg), 32'(THREE));
        run(9);
        disp.display_all = {FIVE, SIX, SEVEN, EIGHT};
        run(11);
        expect_eq("d2_e40_an", 32'(disp.an), 32'b1011);
        expect_eq("d2_e40_old_seg", 32'(disp.seg), 32'(TWO));
        run(23);
        expect_eq("fd_e63", 32'(disp.frame_done), 32'd0);
        step();
        expect_eq("fd_e64", 32'(disp.frame_done), 32'd1);
        run(4);
        expect_eq("new_e68_an", 32'(disp.an), 32'b1110);
        expect_eq("new_e68_seg", 32'(disp.seg), 32'(EIGHT));

        // Blank for edges 10-40, released at edge 41.
        do_reset({ONE, TWO, THREE, FOUR});
        run(9);
        disp.blank = 1'b1;
        run(31);
        expect_eq("blank_e40_an", 32'(disp.an), 32'hF);
        disp.blank = 1'b0;
        step();
        expect_eq("unblank_e41_an", 32'(disp.an), 32'b1011);
        run(23);
        expect_eq("blank_fd_e64", 32'(disp.frame_done), 32'd1);

        // Reset pulse in the middle of the digit 2 slot.
        do_reset({ONE, TWO, THREE, FOUR});
        run(39);
        rst = 1'b1;
        step();
        expect_eq("midrst_an", 32'(disp.an), 32'hF);
        expect_eq("midrst_seg", 32'(disp.seg), 32'h7F);
        expect_eq("midrst_idx", 32'(disp.digit_idx), 32'd0);
        rst = 1'b0;
        run(3);
        expect_eq("midrst_guard_an", 32'(disp.an), 32'hF);
        step();
        expect_eq("midrst_on_an", 32'(disp.an), 32'b1110);

        // Leading-zero words.
        do_reset({ZERO, ZERO, ZERO, SEVEN});
        run(4);
        expect_eq("lz_d0_seg", 32'(disp.seg), 32'(SEVEN));
        run(16);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        expect_eq("lz_d1_an", 32'(disp.an), 32'hF);
`else
        expect_eq("lz_d1_an", 32'(disp.an), 32'b1101);
        expect_eq("lz_d1_seg", 32'(disp.seg), 32'(ZERO));
`endif
        run(60);
        do_reset({ZERO, ZERO, ZERO, ZERO});
        run(4);
        expect_eq("allzero_d0_an", 32'(disp.an), 32'b1110);
        expect_eq("allzero_d0_seg", 32'(disp.seg), 32'(ZERO));
        run(76);

        // Randomized word changes, blanking and occasional resets.
        do_reset(rand_word());
        for (int unsigned c = 0; c < 3000; c++) begin
            if ($urandom_range(9, 0) == 0) disp.display_all = rand_word();
            if ($urandom_range(19, 0) == 0) disp.blank = ~disp.blank;
            rst = ($urandom_range(299, 0) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
